bus_arbiter_ctrl: RTL and testbench
===================================

# bus_arbiter_ctrl

Four-client bus arbiter controller that shares one server port between four requesters using a full four-phase rq/ack handshake on both sides. Selects a winner by strict priority (programmable 2-bit priority per client) or round-robin, holds the grant until the handshake completes, and aborts a grant if the server never acknowledges. Sits between the client request lines and the single server port of the bus arbiter subsystem.

## Interface
- TIMEOUT, 255, max cycles in WAIT_ACK before the grant is aborted; 0 disables the watchdog
- TO_W, 8, width of the watchdog counter; must hold TIMEOUT
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- arb_mode  input  1  0 = strict priority, 1 = round-robin; sampled only in IDLE
- client_N_priority  input  2  per client N = 1..4; 0 highest, 3 lowest; ignored in round-robin
- client_N_rq  input  1  per client N = 1..4; request, level
- client_N_ack  output  1  per client N = 1..4; acknowledge, registered
- server_rq  output  1  request to server, registered
- server_ack  input  1  server acknowledge
- grant_id  output  2  index of granted client (0 = client 1); valid while busy = 1
- busy  output  1  high whenever state != IDLE
- timeout_err  output  1  one-cycle pulse on watchdog abort

## Operation
- Reset (reset = 0, async): state IDLE; all client_N_ack = 0; server_rq = 0; grant_id = 0; busy = 0; timeout_err = 0; watchdog counter = 0; round-robin pointer last_grant = 3, so client 1 wins the first RR arbitration.
- IDLE: if any client_N_rq = 1, latch the winner into grant_id, set server_rq = 1, clear the watchdog, and go to WAIT_ACK. Otherwise stay.
- Strict mode winner: lowest priority value among requesters. Ties go to the lowest client index.
- RR mode winner: first requester found scanning from last_grant+1 upward, wrapping 3 -> 0.
- WAIT_ACK: on server_ack = 1, set client_{grant}_ack = 1 and go to HOLD. Otherwise increment the watchdog.
  - On watchdog = TIMEOUT-1 with TIMEOUT != 0: server_rq = 0, timeout_err = 1 for one cycle, last_grant = grant_id, go to IDLE.
  - No client ack is given on abort.
- HOLD: on client_{grant}_rq = 0, set server_rq = 0 and go to WAIT_REL.
- WAIT_REL: on server_ack = 0, set client_{grant}_ack = 0, set last_grant = grant_id, and go to IDLE.
- Grant is committed once latched:
  - Changes on other clients' rq, on priorities, or on arb_mode do not pre-empt it.
  - If the granted client drops rq during WAIT_ACK, the handshake still completes: HOLD exits on the next cycle.
- At most one client_N_ack is high at any time. server_rq and client acks never change outside the transitions above.
- Stray server_ack = 1 in IDLE is ignored.

## Timing
- Request rq sampled high at edge k (IDLE): server_rq, busy and grant_id are valid after edge k.
- server_ack sampled high at edge m: client_ack is high after edge m.
- client rq sampled low at edge p: server_rq is low after edge p.
- server_ack sampled low at edge q: client_ack is low and busy = 0 after edge q.
- Re-arbitration is possible at edge q+1, which gives a minimum of 1 idle cycle between grants.
- Minimum transaction with a zero-wait server and client is 4 edges, IDLE to IDLE.
- Watchdog: server_rq falls TIMEOUT edges after it rose. timeout_err is high for exactly the following cycle.
- Reset asserted mid-transaction clears all outputs immediately, without waiting for a clock. The first arbitration after reset release uses the reset pointer.

## Test plan
- Strict priority, all four rq = 1, priorities {3,2,1,0}:
  - grants come in order client 4, 3, 2, 1, each with the full four-phase sequence;
  - only one ack is high at any time.
- Strict tie, priorities all 1, clients 2 and 3 requesting -> grant_id = 1 (client 2) first, then 2.
- Round-robin from reset, all rq held high:
  - grant order is 1, 2, 3, 4, 1;
  - grant_id sequence is 0, 1, 2, 3, 0;
  - priorities set to favour client 4 have no effect.
- Mid-grant change: during HOLD of client 1, raise client 4 rq and flip arb_mode:
  - client 1's transaction completes undisturbed;
  - the new mode applies at the next IDLE.
- Watchdog, TIMEOUT = 4, server never acks:
  - server_rq is high for 4 cycles, then timeout_err pulses for 1 cycle;
  - no client_ack is given;
  - the RR pointer advances.
- Reset pulled low during HOLD: all acks, server_rq and busy = 0 asynchronously; the next RR arbitration starts at client 1.

Source files
------------

// File: rtl/bus_arbiter_ctrl.sv
// Four-client bus arbiter: strict-priority or round-robin selection, four-phase
// rq/ack handshake toward both the clients and the single server port.
//
// state    | meaning
// IDLE     | no grant; arbitrate when any client requests
// WAIT_ACK | server_rq high, waiting for server_ack (watchdog running)
// HOLD     | server acked, granted client acked, waiting for client rq to drop
// WAIT_REL | server_rq dropped, waiting for server_ack to drop
module bus_arbiter_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       arb_mode,
   input  logic [1:0] client_1_priority,
   input  logic [1:0] client_2_priority,
   input  logic [1:0] client_3_priority,
   input  logic [1:0] client_4_priority,
   input  logic       client_1_rq,
   input  logic       client_2_rq,
   input  logic       client_3_rq,
   input  logic       client_4_rq,
   output logic       client_1_ack,
   output logic       client_2_ack,
   output logic       client_3_ack,
   output logic       client_4_ack,
   output logic       server_rq,
   input  logic       server_ack,
   output logic [1:0] grant_id,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, HOLD, WAIT_REL} state_t;

   localparam bit              WD_EN   = (TIMEOUT != 0);
   localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t          state;
   logic [3:0]      ack;
   logic [TO_W-1:0] wdog;
   logic [1:0]      last_grant;

   logic [3:0] rq;
   logic [1:0] pri [4];
   logic [1:0] win_strict, win_rr, winner, best, idx;
   logic       found, found_rr;

   assign rq     = {client_4_rq, client_3_rq, client_2_rq, client_1_rq};
   assign pri[0] = client_1_priority;
   assign pri[1] = client_2_priority;
   assign pri[2] = client_3_priority;
   assign pri[3] = client_4_priority;

   // Strict '<' keeps the lower index on equal priority values.
   always_comb begin
      win_strict = 2'd0;
      best       = 2'd3;
      found      = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (rq[i] && (!found || pri[i] < best)) begin
            found      = 1'b1;
            best       = pri[i];
            win_strict = 2'(i);
         end
      end
   end

   always_comb begin
      win_rr   = 2'd0;
      found_rr = 1'b0;
      idx      = 2'd0;
      for (int off = 1; off <= 4; off++) begin
         idx = last_grant + 2'(off);
         if (!found_rr && rq[idx]) begin
            found_rr = 1'b1;
            win_rr   = idx;
         end
      end
   end

   assign winner = arb_mode ? win_rr : win_strict;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ack         <= 4'b0000;
         server_rq   <= 1'b0;
         grant_id    <= 2'd0;
         timeout_err <= 1'b0;
         wdog        <= '0;
         last_grant  <= 2'd3;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (|rq) begin
                  grant_id  <= winner;
                  server_rq <= 1'b1;
                  wdog      <= '0;
                  state     <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (server_ack) begin
                  ack   <= 4'b0001 << grant_id;
                  state <= HOLD;
               end else if (WD_EN && wdog == WD_LAST) begin
                  server_rq   <= 1'b0;
                  timeout_err <= 1'b1;
                  last_grant  <= grant_id;
                  state       <= IDLE;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            HOLD: begin
               if (!rq[grant_id]) begin
                  server_rq <= 1'b0;
                  state     <= WAIT_REL;
               end
            end
            WAIT_REL: begin
               if (!server_ack) begin
                  ack        <= 4'b0000;
                  last_grant <= grant_id;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy         = (state != IDLE);
   assign client_1_ack = ack[0];
   assign client_2_ack = ack[1];
   assign client_3_ack = ack[2];
   assign client_4_ack = ack[3];

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Table-driven bench for bus_arbiter_ctrl: one record per clock edge with the
// inputs applied before the edge and the outputs expected just after it.
module tb_bus_arbiter_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       arb_mode;
   logic [7:0] pri;
   logic [3:0] rq;
   logic       server_ack;
   logic [3:0] ack;
   logic       server_rq;
   logic [1:0] grant_id;
   logic       busy;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_arbiter_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
      .clk               (clk),
      .reset             (reset),
      .arb_mode          (arb_mode),
      .client_1_priority (pri[1:0]),
      .client_2_priority (pri[3:2]),
      .client_3_priority (pri[5:4]),
      .client_4_priority (pri[7:6]),
      .client_1_rq       (rq[0]),
      .client_2_rq       (rq[1]),
      .client_3_rq       (rq[2]),
      .client_4_rq       (rq[3]),
      .client_1_ack      (ack[0]),
      .client_2_ack      (ack[1]),
      .client_3_ack      (ack[2]),
      .client_4_ack      (ack[3]),
      .server_rq         (server_rq),
      .server_ack        (server_ack),
      .grant_id          (grant_id),
      .busy              (busy),
      .timeout_err       (timeout_err)
   );

   typedef struct {
      string      name;
      logic       do_rst;
      logic [3:0] rq;
      logic [7:0] pri;
      logic       mode;
      logic       sack;
      logic [3:0] ack;
      logic       srq;
      logic [1:0] gid;
      logic       busy;
      logic       terr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string n, input logic r, input logic [3:0] q, input logic [7:0] p,
                      input logic m, input logic s, input logic [3:0] a, input logic sr,
                      input logic [1:0] g, input logic b, input logic t);
      vec_t v;
      v.name = n; v.do_rst = r; v.rq = q; v.pri = p; v.mode = m; v.sack = s;
      v.ack = a; v.srq = sr; v.gid = g; v.busy = b; v.terr = t;
      vecs.push_back(v);
   endtask

   task automatic check(input string n, input logic [3:0] a, input logic sr,
                        input logic [1:0] g, input logic b, input logic t);
      logic [8:0] got, exp;
      got = {ack, server_rq, grant_id, busy, timeout_err};
      exp = {a, sr, g, b, t};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got ack=%b srq=%b gid=%0d busy=%b terr=%b, want ack=%b srq=%b gid=%0d busy=%b terr=%b",
                  n, got[8:5], got[4], got[3:2], got[1], got[0], a, sr, g, b, t);
      end
   endtask

   task automatic step(input vec_t v);
      if (v.do_rst) begin
         reset = 1'b0;
         #2;
         reset = 1'b1;
      end
      rq = v.rq; pri = v.pri; arb_mode = v.mode; server_ack = v.sack;
      @(posedge clk);
      #1;
      check(v.name, v.ack, v.srq, v.gid, v.busy, v.terr);
   endtask

   initial begin
      // Strict priority, client 4 best ... client 1 worst.
      add("sp_c4_grant", 0, 4'b1111, 8'h1B, 0, 0, 4'b0000, 1, 2'd3, 1, 0);
      add("sp_c4_ack",   0, 4'b1111, 8'h1B, 0, 1, 4'b1000, 1, 2'd3, 1, 0);
      add("sp_c4_rqlo",  0, 4'b0111, 8'h1B, 0, 1, 4'b1000, 0, 2'd3, 1, 0);
      add("sp_c4_done",  0, 4'b0111, 8'h1B, 0, 0, 4'b0000, 0, 2'd3, 0, 0);
      add("sp_c3_grant", 0, 4'b0111, 8'h1B, 0, 0, 4'b0000, 1, 2'd2, 1, 0);
      add("sp_c3_ack",   0, 4'b0111, 8'h1B, 0, 1, 4'b0100, 1, 2'd2, 1, 0);
      add("sp_c3_rqlo",  0, 4'b0011, 8'h1B, 0, 1, 4'b0100, 0, 2'd2, 1, 0);
      add("sp_c3_done",  0, 4'b0011, 8'h1B, 0, 0, 4'b0000, 0, 2'd2, 0, 0);
      add("sp_c2_grant", 0, 4'b0011, 8'h1B, 0, 0, 4'b0000, 1, 2'd1, 1, 0);
      add("sp_c2_ack",   0, 4'b0011, 8'h1B, 0, 1, 4'b0010, 1, 2'd1, 1, 0);
      add("sp_c2_rqlo",  0, 4'b0001, 8'h1B, 0, 1, 4'b0010, 0, 2'd1, 1, 0);
      add("sp_c2_done",  0, 4'b0001, 8'h1B, 0, 0, 4'b0000, 0, 2'd1, 0, 0);
      add("sp_c1_grant", 0, 4'b0001, 8'h1B, 0, 0, 4'b0000, 1, 2'd0, 1, 0);
      add("sp_c1_ack",   0, 4'b0001, 8'h1B, 0, 1, 4'b0001, 1, 2'd0, 1, 0);
      add("sp_c1_rqlo",  0, 4'b0000, 8'h1B, 0, 1, 4'b0001, 0, 2'd0, 1, 0);
      add("sp_c1_done",  0, 4'b0000, 8'h1B, 0, 0, 4'b0000, 0, 2'd0, 0, 0);
      add("stray_ack",   0, 4'b0000, 8'h1B, 0, 1, 4'b0000, 0, 2'd0, 0, 0);
      // Strict tie: clients 2 and 3, equal priority.
      add("tie_c2",      0, 4'b0110, 8'h55, 0, 0, 4'b0000, 1, 2'd1, 1, 0);
      add("tie_c2_ack",  0, 4'b0110, 8'h55, 0, 1, 4'b0010, 1, 2'd1, 1, 0);
      add("tie_c2_rqlo", 0, 4'b0100, 8'h55, 0, 1, 4'b0010, 0, 2'd1, 1, 0);
      add("tie_c2_done", 0, 4'b0100, 8'h55, 0, 0, 4'b0000, 0, 2'd1, 0, 0);
      add("tie_c3",      0, 4'b0100, 8'h55, 0, 0, 4'b0000, 1, 2'd2, 1, 0);
      add("tie_c3_ack",  0, 4'b0100, 8'h55, 0, 1, 4'b0100, 1, 2'd2, 1, 0);
      add("tie_c3_rqlo", 0, 4'b0000, 8'h55, 0, 1, 4'b0100, 0, 2'd2, 1, 0);
      add("tie_c3_done", 0, 4'b0000, 8'h55, 0, 0, 4'b0000, 0, 2'd2, 0, 0);
      // Round-robin from reset; priorities favour client 4 but must not matter.
      add("rr_c1",       1, 4'b1111, 8'h3F, 1, 0, 4'b0000, 1, 2'd0, 1, 0);
      add("rr_c1_ack",   0, 4'b1111, 8'h3F, 1, 1, 4'b0001, 1, 2'd0, 1, 0);
      add("rr_c1_rqlo",  0, 4'b1110, 8'h3F, 1, 1, 4'b0001, 0, 2'd0, 1, 0);
      add("rr_c1_done",  0, 4'b1110, 8'h3F, 1, 0, 4'b0000, 0, 2'd0, 0, 0);
      add("rr_c2",       0, 4'b1111, 8'h3F, 1, 0, 4'b0000, 1, 2'd1, 1, 0);
      add("rr_c2_ack",   0, 4'b1111, 8'h3F, 1, 1, 4'b0010, 1, 2'd1, 1, 0);
      add("rr_c2_rqlo",  0, 4'b1101, 8'h3F, 1, 1, 4'b0010, 0, 2'd1, 1, 0);
      add("rr_c2_done",  0, 4'b1101, 8'h3F, 1, 0, 4'b0000, 0, 2'd1, 0, 0);
      add("rr_c3",       0, 4'b1111, 8'h3F, 1, 0, 4'b0000, 1, 2'd2, 1, 0);
      add("rr_c3_ack",   0, 4'b1111, 8'h3F, 1, 1, 4'b0100, 1, 2'd2, 1, 0);
      add("rr_c3_rqlo",  0, 4'b1011, 8'h3F, 1, 1, 4'b0100, 0, 2'd2, 1, 0);
      add("rr_c3_done",  0, 4'b1011, 8'h3F, 1, 0, 4'b0000, 0, 2'd2, 0, 0);
      add("rr_c4",       0, 4'b1111, 8'h3F, 1, 0, 4'b0000, 1, 2'd3, 1, 0);
      add("rr_c4_ack",   0, 4'b1111, 8'h3F, 1, 1, 4'b1000, 1, 2'd3, 1, 0);
      add("rr_c4_rqlo",  0, 4'b0111, 8'h3F, 1, 1, 4'b1000, 0, 2'd3, 1, 0);
      add("rr_c4_done",  0, 4'b0111, 8'h3F, 1, 0, 4'b0000, 0, 2'd3, 0, 0);
      add("rr_c1_again", 0, 4'b1111, 8'h3F, 1, 0, 4'b0000, 1, 2'd0, 1, 0);
      add("rr_c1b_ack",  0, 4'b1111, 8'h3F, 1, 1, 4'b0001, 1, 2'd0, 1, 0);
      add("rr_c1b_rqlo", 0, 4'b1110, 8'h3F, 1, 1, 4'b0001, 0, 2'd0, 1, 0);
      add("rr_c1b_done", 0, 4'b1110, 8'h3F, 1, 0, 4'b0000, 0, 2'd0, 0, 0);
      // Mid-grant: client 4 raises rq and mode flips to strict during HOLD.
      add("mg_c1",       0, 4'b0001, 8'h3F, 1, 0, 4'b0000, 1, 2'd0, 1, 0);
      add("mg_c1_ack",   0, 4'b0001, 8'h3F, 1, 1, 4'b0001, 1, 2'd0, 1, 0);
      add("mg_hold",     0, 4'b1001, 8'h3F, 0, 1, 4'b0001, 1, 2'd0, 1, 0);
      add("mg_c1_rqlo",  0, 4'b1000, 8'h3F, 0, 1, 4'b0001, 0, 2'd0, 1, 0);
      add("mg_c1_done",  0, 4'b1000, 8'h3F, 0, 0, 4'b0000, 0, 2'd0, 0, 0);
      add("mg_strict",   0, 4'b1010, 8'h3F, 0, 0, 4'b0000, 1, 2'd3, 1, 0);
      add("mg_c4_ack",   0, 4'b1010, 8'h3F, 0, 1, 4'b1000, 1, 2'd3, 1, 0);
      add("mg_c4_rqlo",  0, 4'b0010, 8'h3F, 0, 1, 4'b1000, 0, 2'd3, 1, 0);
      add("mg_c4_done",  0, 4'b0000, 8'h3F, 0, 0, 4'b0000, 0, 2'd3, 0, 0);
      // Watchdog (TIMEOUT = 4), server never acks client 3.
      add("wd_rise",     0, 4'b0100, 8'h3F, 1, 0, 4'b0000, 1, 2'd2, 1, 0);
      add("wd_wait1",    0, 4'b0100, 8'h3F, 1, 0, 4'b0000, 1, 2'd2, 1, 0);
      add("wd_wait2",    0, 4'b0100, 8'h3F, 1, 0, 4'b0000, 1, 2'd2, 1, 0);
      add("wd_wait3",    0, 4'b0100, 8'h3F, 1, 0, 4'b0000, 1, 2'd2, 1, 0);
      add("wd_abort",    0, 4'b0100, 8'h3F, 1, 0, 4'b0000, 0, 2'd2, 0, 1);
      add("wd_ptr_adv",  0, 4'b1001, 8'h3F, 1, 0, 4'b0000, 1, 2'd3, 1, 0);
      add("wd_c4_ack",   0, 4'b1001, 8'h3F, 1, 1, 4'b1000, 1, 2'd3, 1, 0);
      add("wd_c4_rqlo",  0, 4'b0001, 8'h3F, 1, 1, 4'b1000, 0, 2'd3, 1, 0);
      add("wd_c4_done",  0, 4'b0000, 8'h3F, 1, 0, 4'b0000, 0, 2'd3, 0, 0);
      // Granted client drops rq while still in WAIT_ACK.
      add("ea_c2",       0, 4'b0010, 8'h3F, 1, 0, 4'b0000, 1, 2'd1, 1, 0);
      add("ea_wait",     0, 4'b0000, 8'h3F, 1, 0, 4'b0000, 1, 2'd1, 1, 0);
      add("ea_ack",      0, 4'b0000, 8'h3F, 1, 1, 4'b0010, 1, 2'd1, 1, 0);
      add("ea_hold_exit",0, 4'b0000, 8'h3F, 1, 1, 4'b0010, 0, 2'd1, 1, 0);
      add("ea_done",     0, 4'b0000, 8'h3F, 1, 0, 4'b0000, 0, 2'd1, 0, 0);
      // Lead-in to the reset-during-HOLD sequence.
      add("rs_c3",       0, 4'b0100, 8'h3F, 1, 0, 4'b0000, 1, 2'd2, 1, 0);
      add("rs_c3_hold",  0, 4'b0100, 8'h3F, 1, 1, 4'b0100, 1, 2'd2, 1, 0);

      reset = 1'b0; rq = 4'b0000; pri = 8'h00; arb_mode = 1'b0; server_ack = 1'b0;
      #3;
      check("reset_state", 4'b0000, 0, 2'd0, 0, 0);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

      // Asynchronous reset in HOLD, checked before any further clock edge.
      reset = 1'b0;
      #2;
      check("rst_async", 4'b0000, 0, 2'd0, 0, 0);
      reset = 1'b1;
      rq = 4'b1111; arb_mode = 1'b1; server_ack = 1'b0;
      @(posedge clk);
      #1;
      check("rst_rr_c1", 4'b0000, 1, 2'd0, 1, 0);
      server_ack = 1'b1;
      @(posedge clk);
      #1;
      check("rst_c1_ack", 4'b0001, 1, 2'd0, 1, 0);
      rq = 4'b0000;
      @(posedge clk);
      #1;
      check("rst_c1_rqlo", 4'b0001, 0, 2'd0, 1, 0);
      server_ack = 1'b0;
      @(posedge clk);
      #1;
      check("rst_c1_done", 4'b0000, 0, 2'd0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
